systolic_result_drain: RTL

Unloads the accumulated results of the size x size systolic MAC array once computation finishes, streaming them out over a val/rdy interface in row-major order. It sits downstream of the systolic array controller: it is started when the array reaches its output state, reads each PE accumulator by address, and pulses an accumulator clear once every result has been accepted.

---
 rtl/systolic_result_drain.sv | 89 ++++++++
 1 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: streams the size x size PE accumulators out row-major over val/rdy, then pulses acc_clr
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        level; array results are final and may be drained
//   row_sel      PE row address being fetched
//   col_sel      PE column address being fetched
//   result_data  accumulator of PE(row_sel, col_sel), combinational
//   recv_msg     result word
//   recv_val     recv_msg valid
//   recv_rdy     consumer accepts recv_msg
//   acc_clr      one-cycle pulse zeroing all PE accumulators
//   done         drain complete, held until start drops
module systolic_result_drain #(
    parameter int size = 16,
    parameter int nbits = 32,
    localparam int aw = (size > 1) ? $clog2(size) : 1,
    localparam int cw = $clog2(size * size + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [aw-1:0]    row_sel,
    output logic [aw-1:0]    col_sel,
    input  logic [nbits-1:0] result_data,
    output logic [nbits-1:0] recv_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic             acc_clr,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;
    state_t state, state_nx;
    logic [aw-1:0] row, col;
    logic [cw-1:0] cnt;
    logic [nbits-1:0] msg;
    logic exhausted, out_valid, xfer, load, last_col, last_row, last_xfer;
    assign last_col = col == aw'(size - 1);
    assign last_row = row == aw'(size - 1);
    assign xfer = state == DRAIN && out_valid && recv_rdy;
    assign last_xfer = xfer && cnt == cw'(size * size - 1);
    // the output register refills whenever it is empty or being emptied this cycle
    assign load = state == DRAIN && !exhausted && (!out_valid || recv_rdy);
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? DRAIN : IDLE;
            DRAIN:   state_nx = last_xfer ? CLEAR : DRAIN;
            CLEAR:   state_nx = DONE;
            default: state_nx = start ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            row <= '0;
            col <= '0;
            cnt <= '0;
            msg <= '0;
            exhausted <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
            cnt <= '0;
            exhausted <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == DRAIN) begin
            if (load) begin
                msg <= result_data;
                out_valid <= 1'b1;
                // the address parks on the last PE once every result has been fetched
                if (!last_col) col <= col + 1'b1;
                else if (!last_row) begin
                    row <= row + 1'b1;
                    col <= '0;
                end else exhausted <= 1'b1;
            end else if (recv_rdy) out_valid <= 1'b0;
            if (xfer) cnt <= cnt + 1'b1;
        end
    assign row_sel = row;
    assign col_sel = col;
    assign recv_msg = msg;
    assign recv_val = out_valid;
    assign acc_clr = state == CLEAR;
    assign done = state == DONE;
endmodule
